// File: rtl/vm_vend_ctrl.sv
// ---------------------------------------------------------------------------
// vm_vend_ctrl -- vending sequencer
//
// Owns the coin credit. It takes coins in half-unit steps and accepts a
// selection of product A or B. It hands the vend to the dispenser over a
// request/acknowledge pair, then pays change back one half-unit pulse at a
// time.
//
// Optional feature macro: VM_TIMEOUT_EN
//   defined   : an idle counter in CREDIT refunds the credit after TIMEOUT
//               cycles (the TIMEOUT parameter exists only in this build)
//   undefined : no counter; credit is held in CREDIT indefinitely
//
// Parameters
//   PRICE_A, PRICE_B : product prices in half-units
//   MAX_CREDIT       : credit ceiling in half-units (fits in 4 bits)
//   TIMEOUT          : idle cycles before auto-refund (VM_TIMEOUT_EN only)
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   coin[1:0]    : coin strobe, bit0 = 0.5 coin, bit1 = 1.0 coin
//   sel[1:0]     : selection strobe, bit0 = A, bit1 = B
//   cancel       : refund request strobe
//   disp_req     : dispense request, held until disp_ack
//   disp_id      : product being dispensed (0 = A, 1 = B)
//   disp_ack     : dispenser done, only looked at in VEND
//   chg_pulse    : one high cycle per half-unit returned
//   credit[3:0]  : current credit in half-units
//   coin_rej     : one-cycle pulse, coin must be returned by the hopper
//   err          : one-cycle pulse, invalid or unaffordable selection
//   dbg_state    : current FSM state (IDLE=0, CREDIT=1, VEND=2, CHANGE=3)
//
// Handshake: disp_req rises one cycle after an accepted selection and stays
// high with disp_id stable until the first edge that samples disp_ack = 1;
// on that edge disp_req drops and the FSM leaves VEND, so an ack held high
// for several cycles is consumed once.
// ---------------------------------------------------------------------------
module vm_vend_ctrl #(
  parameter int unsigned PRICE_A    = 4,
  parameter int unsigned PRICE_B    = 6,
  parameter int unsigned MAX_CREDIT = 15
`ifdef VM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT  = 255
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] coin,
  input  logic [1:0] sel,
  input  logic       cancel,
  output logic       disp_req,
  output logic       disp_id,
  input  logic       disp_ack,
  output logic       chg_pulse,
  output logic [3:0] credit,
  output logic       coin_rej,
  output logic       err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  localparam logic [3:0] PA   = 4'(PRICE_A);
  localparam logic [3:0] PB   = 4'(PRICE_B);
  localparam logic [4:0] MAXC = 5'(MAX_CREDIT);

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       disp_req_q, disp_req_d;
  logic       disp_id_q, disp_id_d;
  logic       chg_pulse_q, chg_pulse_d;
  logic       coin_rej_q, coin_rej_d;
  logic       err_q, err_d;

  // Coin decode: bit0 wins, so 2'b11 is worth one half-unit.
  logic       coin_any;
  logic [1:0] coin_val;
  logic [4:0] coin_sum;
  logic       coin_fits;
  logic       start_refund;
  logic       tmo_hit;

  assign coin_any  = (coin != 2'b00);
  assign coin_val  = coin[0] ? 2'd1 : (coin[1] ? 2'd2 : 2'd0);
  assign coin_sum  = {1'b0, credit_q} + {3'b000, coin_val};
  assign coin_fits = (coin_sum <= MAXC);

`ifdef VM_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       coin_acc;

  assign tmo_hit  = (tmo_q == 8'(TIMEOUT));
  assign coin_acc = (state_q == ST_CREDIT) && !cancel && (sel == 2'b00) &&
                    coin_any && coin_fits;

  // Counts idle CREDIT cycles; any accepted coin or any selection (valid or
  // erroneous) restarts the wait. Rejected coins do not count as activity.
  always_comb begin
    tmo_d = 8'd0;
    if ((state_q == ST_CREDIT) && !cancel && !tmo_hit) begin
      if ((sel != 2'b00) || coin_acc) tmo_d = 8'd0;
      else                            tmo_d = tmo_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 8'd0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    disp_req_d   = disp_req_q;
    disp_id_d    = disp_id_q;
    chg_pulse_d  = 1'b0;
    coin_rej_d   = 1'b0;
    err_d        = 1'b0;
    start_refund = 1'b0;

    case (state_q)
      ST_IDLE: begin
        credit_d   = 4'd0;
        disp_req_d = 1'b0;
        if (coin_any) begin
          credit_d = {2'b00, coin_val};
          state_d  = ST_CREDIT;
        end
      end

      ST_CREDIT: begin
        // cancel (or timeout) > sel > coin; a losing coin is bounced.
        if (cancel || tmo_hit) begin
          coin_rej_d   = coin_any;
          start_refund = 1'b1;
        end else if (sel != 2'b00) begin
          coin_rej_d = coin_any;
          if ((sel == 2'b01) && (credit_q >= PA)) begin
            credit_d   = credit_q - PA;
            disp_id_d  = 1'b0;
            disp_req_d = 1'b1;
            state_d    = ST_VEND;
          end else if ((sel == 2'b10) && (credit_q >= PB)) begin
            credit_d   = credit_q - PB;
            disp_id_d  = 1'b1;
            disp_req_d = 1'b1;
            state_d    = ST_VEND;
          end else begin
            err_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_fits) credit_d   = coin_sum[3:0];
          else           coin_rej_d = 1'b1;
        end
      end

      ST_VEND: begin
        coin_rej_d = coin_any;
        if (disp_ack) begin
          disp_req_d   = 1'b0;
          start_refund = 1'b1;
        end
      end

      ST_CHANGE: begin
        coin_rej_d = coin_any;
        if (credit_q == 4'd0) begin
          state_d = ST_IDLE;
        end else if (!chg_pulse_q) begin
          chg_pulse_d = 1'b1;
          credit_d    = credit_q - 4'd1;
          if (credit_q == 4'd1) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Entering CHANGE already emits the first pulse, so a payout of K
    // half-units spans 2K-1 cycles and the last pulse lands in IDLE.
    if (start_refund) begin
      if (credit_q == 4'd0) begin
        state_d = ST_IDLE;
      end else begin
        chg_pulse_d = 1'b1;
        credit_d    = credit_q - 4'd1;
        state_d     = (credit_q == 4'd1) ? ST_IDLE : ST_CHANGE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      credit_q    <= 4'd0;
      disp_req_q  <= 1'b0;
      disp_id_q   <= 1'b0;
      chg_pulse_q <= 1'b0;
      coin_rej_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      disp_req_q  <= disp_req_d;
      disp_id_q   <= disp_id_d;
      chg_pulse_q <= chg_pulse_d;
      coin_rej_q  <= coin_rej_d;
      err_q       <= err_d;
    end
  end

  assign disp_req  = disp_req_q;
  assign disp_id   = disp_id_q;
  assign chg_pulse = chg_pulse_q;
  assign credit    = credit_q;
  assign coin_rej  = coin_rej_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vm_vend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vm_vend_ctrl -- directed bench for vm_vend_ctrl
//
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit after the following rising edge, i.e. they reflect the edge that
// sampled the stimulus. Expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_vm_vend_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_req;
  logic       disp_id;
  logic       disp_ack;
  logic       chg_pulse;
  logic [3:0] credit;
  logic       coin_rej;
  logic       err;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  vm_vend_ctrl #(
    .PRICE_A   (4),
    .PRICE_B   (6),
    .MAX_CREDIT(15)
`ifdef VM_TIMEOUT_EN
    , .TIMEOUT (10)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coin     (coin),
    .sel      (sel),
    .cancel   (cancel),
    .disp_req (disp_req),
    .disp_id  (disp_id),
    .disp_ack (disp_ack),
    .chg_pulse(chg_pulse),
    .credit   (credit),
    .coin_rej (coin_rej),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put_coin(input logic [1:0] v);
    coin = v;
    tick();
    coin = 2'b00;
  endtask

  // Call with the first CHANGE cycle visible; counts pulses until IDLE.
  task automatic drain(input string tag, input int k);
    int pulses = 0;
    int cyc    = 0;
    while (cyc < 100) begin
      if (chg_pulse === 1'b1) pulses++;
      cyc++;
      if (dbg_state === S_IDLE) break;
      tick();
    end
    chk({tag, "_pulses"}, pulses, k);
    chk({tag, "_cycles"}, cyc, 2 * k - 1);
    chk({tag, "_credit"}, credit, 0);
    tick();
    chk({tag, "_pulse_low"}, chg_pulse, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    disp_req,  0);
    chk({tag, "_id"},     disp_id,   0);
    chk({tag, "_pulse"},  chg_pulse, 0);
    chk({tag, "_credit"}, credit,    0);
    chk({tag, "_rej"},    coin_rej,  0);
    chk({tag, "_err"},    err,       0);
    chk({tag, "_state"},  dbg_state, S_IDLE);
  endtask

  initial begin
    bit held;
    int wait_cyc;

    rst_n    = 1'b0;
    coin     = 2'b00;
    sel      = 2'b00;
    cancel   = 1'b0;
    disp_ack = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // sel in IDLE is ignored
    sel = 2'b01;
    tick();
    sel = 2'b00;
    chk("idle_sel_err", err, 0);
    chk("idle_sel_state", dbg_state, S_IDLE);

    // credit 4, buy A, no change
    put_coin(2'b01);
    chk("t1_c1", credit, 1);
    chk("t1_state_credit", dbg_state, S_CREDIT);
    put_coin(2'b10);
    chk("t1_c3", credit, 3);
    put_coin(2'b01);
    chk("t1_c4", credit, 4);
    sel = 2'b01;
    tick();
    sel = 2'b00;
    chk("t1_req", disp_req, 1);
    chk("t1_id", disp_id, 0);
    chk("t1_credit", credit, 0);
    chk("t1_state_vend", dbg_state, S_VEND);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    chk("t1_req_drop", disp_req, 0);
    chk("t1_no_pulse", chg_pulse, 0);
    chk("t1_idle", dbg_state, S_IDLE);
    tick();
    chk("t1_no_pulse2", chg_pulse, 0);

    // credit 7, buy B, one half-unit change
    put_coin(2'b10);
    put_coin(2'b10);
    put_coin(2'b10);
    put_coin(2'b01);
    chk("t2_c7", credit, 7);
    sel = 2'b10;
    tick();
    sel = 2'b00;
    chk("t2_req", disp_req, 1);
    chk("t2_id", disp_id, 1);
    chk("t2_credit", credit, 1);
    tick();
    chk("t2_req_held", disp_req, 1);
    chk("t2_id_held", disp_id, 1);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    chk("t2_req_drop", disp_req, 0);
    drain("t2", 1);
    chk("t2_idle", dbg_state, S_IDLE);

    // credit ceiling
    for (int i = 0; i < 7; i++) put_coin(2'b10);
    chk("t3_c14", credit, 14);
    put_coin(2'b10);
    chk("t3_rej", coin_rej, 1);
    chk("t3_c14_kept", credit, 14);
    tick();
    chk("t3_rej_low", coin_rej, 0);
    put_coin(2'b01);
    chk("t3_c15", credit, 15);
    chk("t3_no_rej", coin_rej, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t3_change", dbg_state, S_CHANGE);
    drain("t3", 15);

    // unaffordable / invalid selection, then cancel racing a coin
    put_coin(2'b10);
    put_coin(2'b01);
    chk("t4_c3", credit, 3);
    sel = 2'b01;
    tick();
    sel = 2'b00;
    chk("t4_err", err, 1);
    chk("t4_state", dbg_state, S_CREDIT);
    chk("t4_credit", credit, 3);
    tick();
    chk("t4_err_low", err, 0);
    sel  = 2'b11;
    coin = 2'b01;
    tick();
    sel  = 2'b00;
    coin = 2'b00;
    chk("t4_err11", err, 1);
    chk("t4_rej_sel", coin_rej, 1);
    chk("t4_credit11", credit, 3);
    cancel = 1'b1;
    coin   = 2'b01;
    tick();
    cancel = 1'b0;
    coin   = 2'b00;
    chk("t4_rej_cancel", coin_rej, 1);
    chk("t4_first_pulse", chg_pulse, 1);
    chk("t4_credit2", credit, 2);
    drain("t4", 3);

    // long VEND with coin strobed, then async reset mid-VEND
    for (int i = 0; i < 4; i++) put_coin(2'b10);
    sel = 2'b10;
    tick();
    sel = 2'b00;
    chk("t5_credit", credit, 2);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) coin = 2'b10;
      tick();
      coin = 2'b00;
      if (disp_req !== 1'b1) held = 1'b0;
      if (i == 5) begin
        chk("t5_rej", coin_rej, 1);
        chk("t5_credit_kept", credit, 2);
      end
    end
    chk("t5_req_held", held, 1);
    chk("t5_state", dbg_state, S_VEND);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    // ack held high across several cycles is consumed once
    for (int i = 0; i < 3; i++) put_coin(2'b10);
    sel = 2'b01;
    tick();
    sel = 2'b00;
    chk("t6_credit", credit, 2);
    disp_ack = 1'b1;
    tick();
    chk("t6_req_drop", disp_req, 0);
    chk("t6_pulse", chg_pulse, 1);
    drain("t6", 2);
    tick();
    chk("t6_ack_ignored", dbg_state, S_IDLE);
    chk("t6_req_stays_low", disp_req, 0);
    disp_ack = 1'b0;

    // coin 2'b11 counts as a half-unit, both in IDLE and CREDIT
    put_coin(2'b11);
    chk("t7_c1", credit, 1);
    chk("t7_no_rej", coin_rej, 0);
    put_coin(2'b11);
    chk("t7_c2", credit, 2);

    // idle credit: timeout refund or indefinite hold
`ifdef VM_TIMEOUT_EN
    wait_cyc = 0;
    while (dbg_state !== S_CHANGE && wait_cyc < 40) begin
      tick();
      wait_cyc++;
    end
    chk("t8_tmo_cycles", wait_cyc, 11);
    drain("t8_tmo", 2);
`else
    wait_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (dbg_state !== S_CREDIT) wait_cyc++;
    end
    chk("t8_hold_credit", credit, 2);
    chk("t8_hold_state", wait_cyc, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    drain("t8_cancel", 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
